// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int unsigned EXC_W      = 16;
    localparam int unsigned LD_TYPE_W  = 5;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CANCEL_W   = 2;
    localparam int unsigned CANCEL_MAX = 2;

    // Load-type one-hot bit positions within {ld_w, ld_h, ld_hu, ld_b, ld_bu}
    localparam int unsigned LD_W_BIT  = 4;
    localparam int unsigned LD_H_BIT  = 3;
    localparam int unsigned LD_HU_BIT = 2;
    localparam int unsigned LD_B_BIT  = 1;
    localparam int unsigned LD_BU_BIT = 0;

    // Exception-vector bit indices
    localparam int unsigned EXC_INT  = 0;
    localparam int unsigned EXC_ADEF = 1;
    localparam int unsigned EXC_ALE  = 2;
    localparam int unsigned EXC_SYS  = 3;
    localparam int unsigned EXC_BRK  = 4;
    localparam int unsigned EXC_INE  = 5;
    localparam int unsigned EXC_ERTN = 6;

    // Execute-stage payload latched by the memory stage
    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            result;
        logic                   res_from_mem;
        logic                   mem_req;
        logic                   rf_we;
        logic [REG_ADDR_W-1:0]  rf_waddr;
        logic [LD_TYPE_W-1:0]   ld_type;
    } es_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a load word and extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0]           rdata,
    input  logic [1:0]            addr,
    input  logic [LD_TYPE_W-1:0]  ld_type,
    output logic [31:0]           result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte lane and halfword lane
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane according to the load type
    always_comb begin
        result = rdata;
        if (ld_type[LD_W_BIT]) begin
            result = rdata;
        end else if (ld_type[LD_H_BIT]) begin
            result = {{16{half_sel[15]}}, half_sel};
        end else if (ld_type[LD_HU_BIT]) begin
            result = {16'b0, half_sel};
        end else if (ld_type[LD_B_BIT]) begin
            result = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_type[LD_BU_BIT]) begin
            result = {24'b0, byte_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: latches execute results, waits for data-SRAM
// responses, drops responses of flushed requests, aligns load data.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned EXC_W = mem_stage_pkg::EXC_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   es_to_ms_valid,
    output logic                   ms_allowin,
    input  logic [31:0]            es_pc,
    input  logic [31:0]            es_result,
    input  logic                   es_res_from_mem,
    input  logic                   es_mem_req,
    input  logic                   es_rf_we,
    input  logic [REG_ADDR_W-1:0]  es_rf_waddr,
    input  logic [LD_TYPE_W-1:0]   es_ld_type,
    input  logic [EXC_W-1:0]       es_except,
    input  logic                   es_req_accepted,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   except_flush,
    input  logic                   ws_allowin,
    output logic                   ms_to_ws_valid,
    output logic [31:0]            ms_pc,
    output logic [31:0]            ms_final_result,
    output logic                   ms_rf_we,
    output logic [REG_ADDR_W-1:0]  ms_rf_waddr,
    output logic                   ms_ld_pending,
    output logic [EXC_W-1:0]       ms_except,
    output logic                   ms_ex
);

    es_bus_t              es_bus;
    es_bus_t              ms_bus;
    logic                 ms_valid;
    logic [EXC_W-1:0]     except_q;
    logic                 data_ok_seen;
    logic [31:0]          rdata_buf;
    logic [CANCEL_W-1:0]  cancel_cnt;
    logic [CANCEL_W-1:0]  cancel_cnt_next;
    logic [CANCEL_W:0]    cancel_sum;
    logic                 data_ok_own;
    logic                 ready_go;
    logic                 accept;
    logic                 leave;
    logic                 capture;
    logic [31:0]          load_word;
    logic [31:0]          load_data;

    assign es_bus = '{pc: es_pc, result: es_result, res_from_mem: es_res_from_mem,
                      mem_req: es_mem_req, rf_we: es_rf_we, rf_waddr: es_rf_waddr,
                      ld_type: es_ld_type};

    assign data_ok_own    = data_sram_data_ok & (cancel_cnt == '0);
    assign ready_go       = ~ms_bus.mem_req | data_ok_seen | data_ok_own;
    assign ms_allowin     = ~ms_valid | (ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ready_go & ~except_flush;
    assign accept         = es_to_ms_valid & ms_allowin;
    assign leave          = ms_to_ws_valid & ws_allowin;
    assign capture        = ms_valid & ms_bus.mem_req & ~data_ok_seen & data_ok_own
                            & ~ws_allowin & ~except_flush;

    // Stage valid bit and latched execute payload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
            ms_bus   <= '0;
            except_q <= '0;
        end else begin
            if (except_flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (accept) begin
                ms_bus   <= es_bus;
                except_q <= es_except;
            end
        end
    end

    // Hold an early response while writeback is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_ok_seen <= 1'b0;
            rdata_buf    <= '0;
        end else if (except_flush | leave) begin
            data_ok_seen <= 1'b0;
        end else if (capture) begin
            data_ok_seen <= 1'b1;
            rdata_buf    <= data_sram_rdata;
        end
    end

    // Count in-flight responses owned by flushed instructions
    always_comb begin
        cancel_sum = {1'b0, cancel_cnt};
        if (except_flush) begin
            if (ms_valid & ms_bus.mem_req & ~data_ok_seen & ~data_ok_own) begin
                cancel_sum = cancel_sum + (CANCEL_W + 1)'(1);
            end
            if (es_req_accepted) begin
                cancel_sum = cancel_sum + (CANCEL_W + 1)'(1);
            end
        end
        if (data_sram_data_ok & (cancel_cnt != '0)) begin
            cancel_sum = cancel_sum - (CANCEL_W + 1)'(1);
        end
        cancel_cnt_next = (cancel_sum > (CANCEL_W + 1)'(CANCEL_MAX))
                          ? CANCEL_W'(CANCEL_MAX) : cancel_sum[CANCEL_W-1:0];
    end

    // Cancel counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cancel_cnt <= '0;
        end else begin
            cancel_cnt <= cancel_cnt_next;
        end
    end

    assign load_word = data_ok_seen ? rdata_buf : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .rdata   (load_word),
        .addr    (ms_bus.result[1:0]),
        .ld_type (ms_bus.ld_type),
        .result  (load_data)
    );

    assign ms_pc           = ms_bus.pc;
    assign ms_final_result = ms_bus.res_from_mem ? load_data : ms_bus.result;
    assign ms_rf_we        = ms_valid & ms_bus.rf_we;
    assign ms_rf_waddr     = ms_bus.rf_waddr;
    assign ms_ld_pending   = ms_valid & ms_bus.res_from_mem & ~ready_go;
    assign ms_except       = except_q & {EXC_W{ms_valid}};
    assign ms_ex           = |ms_except;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: load-extract table, directed
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic        es_res_from_mem;
    logic        es_mem_req;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [4:0]  es_ld_type;
    logic [15:0] es_except;
    logic        es_req_accepted;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        except_flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic        ms_ld_pending;
    logic [15:0] ms_except;
    logic        ms_ex;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_result         (es_result),
        .es_res_from_mem   (es_res_from_mem),
        .es_mem_req        (es_mem_req),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_ld_type        (es_ld_type),
        .es_except         (es_except),
        .es_req_accepted   (es_req_accepted),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .except_flush      (except_flush),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_final_result   (ms_final_result),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_ld_pending     (ms_ld_pending),
        .ms_except         (ms_except),
        .ms_ex             (ms_ex)
    );

    localparam logic [4:0] T_W  = 5'b10000;
    localparam logic [4:0] T_H  = 5'b01000;
    localparam logic [4:0] T_HU = 5'b00100;
    localparam logic [4:0] T_B  = 5'b00010;
    localparam logic [4:0] T_BU = 5'b00001;

    typedef struct {
        logic [4:0]  ld_type;
        logic [1:0]  addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic        is_load;
        logic        mem_req;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [4:0]  ld_type;
        logic [15:0] exc;
    } minst_t;

    typedef struct {
        logic        alive;
        logic [31:0] data;
        int          due;
    } resp_t;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t   vecs[12];
    resp_t  rq[$];
    minst_t m;
    minst_t ni;
    logic   m_valid, m_have, m_ready, e_allowin, e_to_ws, resp_alive, no_dead, leave;
    logic [31:0] m_data;
    int     kind;

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        es_pc             = '0;
        es_result         = '0;
        es_res_from_mem   = 1'b0;
        es_mem_req        = 1'b0;
        es_rf_we          = 1'b0;
        es_rf_waddr       = '0;
        es_ld_type        = '0;
        es_except         = '0;
        es_req_accepted   = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        except_flush      = 1'b0;
        ws_allowin        = 1'b1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic ld,
                        input logic mreq, input logic we, input logic [4:0] wa,
                        input logic [4:0] lt, input logic [15:0] exc);
        es_to_ms_valid  = 1'b1;
        es_pc           = pc;
        es_result       = res;
        es_res_from_mem = ld;
        es_mem_req      = mreq;
        es_rf_we        = we;
        es_rf_waddr     = wa;
        es_ld_type      = lt;
        es_except       = exc;
        es_req_accepted = mreq;
    endtask

    // Load extraction computed from the byte/halfword rules with plain arithmetic
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [4:0] t);
        logic [31:0] bv, hv;
        bv = (w >> (8 * a)) & 32'hFF;
        hv = (w >> (16 * a[1])) & 32'hFFFF;
        case (t)
            T_H:     return (hv >= 32'h8000) ? hv - 32'h10000 : hv;
            T_HU:    return hv;
            T_B:     return (bv >= 32'h80) ? bv - 32'h100 : bv;
            T_BU:    return bv;
            default: return w;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{T_W,  2'd0, 32'h80FF_1234, 32'h80FF_1234};
        vecs[1]  = '{T_B,  2'd3, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[2]  = '{T_BU, 2'd3, 32'h80FF_1234, 32'h0000_0080};
        vecs[3]  = '{T_B,  2'd0, 32'h80FF_1234, 32'h0000_0034};
        vecs[4]  = '{T_B,  2'd2, 32'h80FF_1234, 32'hFFFF_FFFF};
        vecs[5]  = '{T_BU, 2'd2, 32'h80FF_1234, 32'h0000_00FF};
        vecs[6]  = '{T_BU, 2'd1, 32'h80FF_1234, 32'h0000_0012};
        vecs[7]  = '{T_H,  2'd0, 32'h80FF_1234, 32'h0000_1234};
        vecs[8]  = '{T_H,  2'd2, 32'h80FF_1234, 32'hFFFF_80FF};
        vecs[9]  = '{T_HU, 2'd2, 32'h80FF_1234, 32'h0000_80FF};
        vecs[10] = '{T_HU, 2'd2, 32'h8001_0000, 32'h0000_8001};
        vecs[11] = '{T_H,  2'd0, 32'h0000_F00D, 32'hFFFF_F00D};

        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        // Reset state
        check1("rst_allowin", ms_allowin, 1'b1);
        check1("rst_to_ws", ms_to_ws_valid, 1'b0);
        check32("rst_result", ms_final_result, 32'h0);
        check32("rst_pc", ms_pc, 32'h0);
        check1("rst_rf_we", ms_rf_we, 1'b0);
        check32("rst_waddr", 32'(ms_rf_waddr), 32'h0);
        check1("rst_ld_pending", ms_ld_pending, 1'b0);
        check32("rst_except", 32'(ms_except), 32'h0);
        check1("rst_ex", ms_ex, 1'b0);
        step();

        // Load extraction table: accept, then data_ok on the next cycle
        for (int i = 0; i < 12; i++) begin
            idle();
            send(32'h1C00_0000 + 32'(i * 4), 32'h0000_1000 | 32'(vecs[i].addr), 1'b1, 1'b1,
                 1'b1, 5'd4, vecs[i].ld_type, 16'h0);
            step();
            idle();
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = vecs[i].rdata;
            #1;
            check1("tbl_to_ws", ms_to_ws_valid, 1'b1);
            check32("tbl_result", ms_final_result, vecs[i].exp);
            check1("tbl_rf_we", ms_rf_we, 1'b1);
            step();
        end

        // ld_b, response two cycles after accept
        idle();
        send(32'h1C00_0100, 32'h0000_2003, 1'b1, 1'b1, 1'b1, 5'd7, T_B, 16'h0);
        step();
        for (int k = 0; k < 2; k++) begin
            idle();
            #1;
            check1("ldb_pending", ms_ld_pending, 1'b1);
            check1("ldb_to_ws", ms_to_ws_valid, 1'b0);
            check1("ldb_allowin", ms_allowin, 1'b0);
            step();
        end
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        #1;
        check1("ldb_done_to_ws", ms_to_ws_valid, 1'b1);
        check32("ldb_result", ms_final_result, 32'hFFFF_FF80);
        check1("ldb_done_pending", ms_ld_pending, 1'b0);
        step();

        // ld_hu, response buffered while writeback stalls
        idle();
        send(32'h1C00_0104, 32'h0000_3002, 1'b1, 1'b1, 1'b1, 5'd8, T_HU, 16'h0);
        step();
        idle();
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_0000;
        #1;
        check1("ldhu_to_ws", ms_to_ws_valid, 1'b1);
        check1("ldhu_allowin", ms_allowin, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            idle();
            ws_allowin      = 1'b0;
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            check32("ldhu_buf_result", ms_final_result, 32'h0000_8001);
            check1("ldhu_buf_pending", ms_ld_pending, 1'b0);
            step();
        end
        idle();
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        check32("ldhu_rel_result", ms_final_result, 32'h0000_8001);
        check1("ldhu_rel_allowin", ms_allowin, 1'b1);
        step();
        #1;
        check1("ldhu_gone", ms_to_ws_valid, 1'b0);

        // st_w waits for data_ok and writes no register
        idle();
        send(32'h1C00_0108, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 5'd0, 5'b0, 16'h0);
        step();
        idle();
        #1;
        check1("st_wait_to_ws", ms_to_ws_valid, 1'b0);
        check1("st_rf_we", ms_rf_we, 1'b0);
        check1("st_pending", ms_ld_pending, 1'b0);
        step();
        idle();
        data_sram_data_ok = 1'b1;
        #1;
        check1("st_done_to_ws", ms_to_ws_valid, 1'b1);
        check32("st_result", ms_final_result, 32'h0000_0100);
        step();

        // Flush with load waiting plus a request accepted the same cycle
        idle();
        send(32'h1C00_010C, 32'h0000_4000, 1'b1, 1'b1, 1'b1, 5'd9, T_W, 16'h0);
        step();
        idle();
        except_flush    = 1'b1;
        es_req_accepted = 1'b1;
        #1;
        check1("fl_to_ws", ms_to_ws_valid, 1'b0);
        step();
        idle();
        #1;
        check1("fl_after_allowin", ms_allowin, 1'b1);
        check1("fl_after_pending", ms_ld_pending, 1'b0);
        send(32'h1C00_0110, 32'h0000_5000, 1'b1, 1'b1, 1'b1, 5'd10, T_W, 16'h0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        #1;
        check1("fl_stale1_to_ws", ms_to_ws_valid, 1'b0);
        step();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h2222_2222;
        #1;
        check1("fl_stale2_to_ws", ms_to_ws_valid, 1'b0);
        check1("fl_stale2_pending", ms_ld_pending, 1'b1);
        step();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        check1("fl_own_to_ws", ms_to_ws_valid, 1'b1);
        check32("fl_own_result", ms_final_result, 32'hCAFE_F00D);
        step();

        // Exception vector visible, then cleared by flush
        idle();
        send(32'h1C00_0114, 32'h0000_0042, 1'b0, 1'b0, 1'b1, 5'd3, 5'b0, 16'h0004);
        step();
        idle();
        ws_allowin = 1'b0;
        #1;
        check1("exc_ex", ms_ex, 1'b1);
        check32("exc_vec", 32'(ms_except), 32'h0004);
        step();
        idle();
        ws_allowin   = 1'b0;
        except_flush = 1'b1;
        #1;
        check1("exc_flush_to_ws", ms_to_ws_valid, 1'b0);
        step();
        idle();
        #1;
        check1("exc_cleared_ex", ms_ex, 1'b0);
        check32("exc_cleared_vec", 32'(ms_except), 32'h0);

        // Back-to-back ALU ops, one per cycle
        for (int k = 0; k < 5; k++) begin
            idle();
            send(32'h1C00_0200 + 32'(k * 4), 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 1'b1,
                 5'(k + 1), 5'b0, 16'h0);
            #1;
            if (k > 0) begin
                check1("alu_to_ws", ms_to_ws_valid, 1'b1);
                check32("alu_result", ms_final_result, 32'hA000_0000 + 32'(k - 1));
                check32("alu_waddr", 32'(ms_rf_waddr), 32'(k));
                check1("alu_allowin", ms_allowin, 1'b1);
            end
            step();
        end
        idle();
        #1;
        check32("alu_last_result", ms_final_result, 32'hA000_0004);
        step();

        // Asynchronous reset while a load is waiting
        idle();
        send(32'h1C00_0300, 32'h0000_6000, 1'b1, 1'b1, 1'b1, 5'd11, T_W, 16'h0);
        step();
        idle();
        #1;
        check1("arst_pending_before", ms_ld_pending, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check1("arst_pending", ms_ld_pending, 1'b0);
        check1("arst_allowin", ms_allowin, 1'b1);
        step();
        reset = 1'b0;

        // Randomized traffic against the queue-based reference model
        m       = '{default: '0};
        m_valid = 1'b0;
        m_have  = 1'b0;
        m_data  = '0;
        rq.delete();
        for (int c = 0; c < 3000; c++) begin
            idle();
            no_dead = 1'b1;
            foreach (rq[i]) if (!rq[i].alive) no_dead = 1'b0;
            resp_alive = 1'b0;
            if (rq.size() > 0) begin
                if (rq[0].due <= c) begin
                    data_sram_data_ok = 1'b1;
                    data_sram_rdata   = rq[0].data;
                    resp_alive        = rq[0].alive;
                end
            end
            if (!data_sram_data_ok) data_sram_rdata = $urandom();
            except_flush = no_dead && ($urandom_range(0, 19) == 0);
            ws_allowin   = ($urandom_range(0, 3) != 0);
            kind         = int'($urandom_range(0, 2));
            ni.pc      = $urandom();
            ni.result  = $urandom();
            ni.is_load = (kind == 1);
            ni.mem_req = (kind != 0);
            ni.rf_we   = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
            ni.waddr   = 5'($urandom());
            ni.ld_type = (kind == 1) ? 5'(1 << $urandom_range(0, 4)) : 5'b0;
            ni.exc     = (kind == 0 && $urandom_range(0, 15) == 0)
                         ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
            es_to_ms_valid  = ($urandom_range(0, 3) != 0);
            es_pc           = ni.pc;
            es_result       = ni.result;
            es_res_from_mem = ni.is_load;
            es_mem_req      = ni.mem_req;
            es_rf_we        = ni.rf_we;
            es_rf_waddr     = ni.waddr;
            es_ld_type      = ni.ld_type;
            es_except       = ni.exc;

            m_ready   = !m.mem_req || m_have || resp_alive;
            e_allowin = !m_valid || (m_ready && ws_allowin);
            e_to_ws   = m_valid && m_ready && !except_flush;
            es_req_accepted = (es_to_ms_valid && ni.mem_req && e_allowin)
                              || (except_flush && $urandom_range(0, 1) == 1);
            #1;
            check1("rnd_allowin", ms_allowin, e_allowin);
            check1("rnd_to_ws", ms_to_ws_valid, e_to_ws);
            check1("rnd_ld_pending", ms_ld_pending, m_valid && m.is_load && !m_ready);
            check1("rnd_rf_we", ms_rf_we, m_valid && m.rf_we);
            check32("rnd_except", 32'(ms_except), m_valid ? 32'(m.exc) : 32'h0);
            check1("rnd_ex", ms_ex, m_valid && (m.exc != 16'h0));
            if (m_valid) begin
                check32("rnd_pc", ms_pc, m.pc);
                check32("rnd_waddr", 32'(ms_rf_waddr), 32'(m.waddr));
            end
            if (e_to_ws) begin
                check32("rnd_result", ms_final_result,
                        m.is_load ? ref_load(m_have ? m_data : data_sram_rdata,
                                             m.result[1:0], m.ld_type) : m.result);
            end

            leave = e_to_ws && ws_allowin;
            if (data_sram_data_ok) void'(rq.pop_front());
            if (except_flush) begin
                foreach (rq[i]) rq[i].alive = 1'b0;
            end
            if (resp_alive && !leave && !except_flush) begin
                m_have = 1'b1;
                m_data = data_sram_rdata;
            end
            if (leave || except_flush) m_have = 1'b0;
            if (es_req_accepted) begin
                rq.push_back('{alive: !except_flush, data: $urandom(),
                               due: c + int'($urandom_range(1, 4))});
            end
            if (except_flush) begin
                m_valid = 1'b0;
            end else if (e_allowin) begin
                m_valid = es_to_ms_valid;
                if (es_to_ms_valid) m = ni;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and writeback. Latches execute-stage results, waits for the data-SRAM response of any load/store issued by execute, aligns and sign/zero-extends load data, and presents the final result to writeback. It also publishes forwarding/blocking info and its exception state back to execute. It discards responses belonging to instructions flushed after their request was accepted.

## Interface
Parameters:
- EXC_W, 16, width of the exception vector carried from execute.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- es_to_ms_valid  in  1  execute has an instruction ready.
- ms_allowin  out  1  stage can accept an instruction this cycle.
- es_pc  in  32  instruction PC.
- es_result  in  32  execute result; for memory ops, the virtual address (bits [1:0] used for alignment).
- es_res_from_mem  in  1  instruction is a load.
- es_mem_req  in  1  execute issued a data-SRAM request for this instruction.
- es_rf_we  in  1  register-file write enable.
- es_rf_waddr  in  5  destination register.
- es_ld_type  in  5  one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}.
- es_except  in  EXC_W  exception vector from execute.
- es_req_accepted  in  1  data_sram_req & data_sram_addr_ok seen by execute this cycle.
- data_sram_data_ok  in  1  SRAM response valid.
- data_sram_rdata  in  32  SRAM read data.
- except_flush  in  1  writeback-raised flush.
- ws_allowin  in  1  writeback can accept.
- ms_to_ws_valid  out  1  instruction leaves this cycle.
- ms_pc  out  32  latched PC.
- ms_final_result  out  32  load data (extended) or es_result.
- ms_rf_we  out  1  ms_valid & latched rf_we.
- ms_rf_waddr  out  5  latched destination.
- ms_ld_pending  out  1  valid load still awaiting data (execute/decode must stall, not forward).
- ms_except  out  EXC_W  latched vector & {EXC_W{ms_valid}}.
- ms_ex  out  1  |ms_except; used by execute to suppress new requests.

## Operation
- Accept: when es_to_ms_valid & ms_allowin, latch all es_* fields; ms_valid <= es_to_ms_valid when ms_allowin. except_flush clears ms_valid (priority over accept).
- ready_go = ~ms_mem_req | data_ok_seen | data_sram_data_ok_own, where data_sram_data_ok_own = data_sram_data_ok & (cancel_cnt == 0).
- ms_allowin = ~ms_valid | ready_go & ws_allowin; ms_to_ws_valid = ms_valid & ready_go & ~except_flush.
- Response buffer: if own data_ok arrives while ws_allowin is low, capture rdata into rdata_buf and set data_ok_seen; cleared when the instruction leaves or on flush.
- Cancel counter (2 bits, max 2): on except_flush, increment by number of accepted-but-unanswered requests: +1 if ms_valid & ms_mem_req & ~data_ok_seen & ~own data_ok this cycle; +1 if es_req_accepted. While cancel_cnt > 0, each data_sram_data_ok decrements it and is ignored. Increment and decrement in the same cycle net out.
- Load extract, shift = addr[1:0]*8: ld_w raw word; ld_b/bu byte at shift, sign/zero-extended; ld_h/hu halfword at {addr[1],4'b0}, sign/zero-extended. Non-loads: ms_final_result = es_result. Stores produce no result but still wait for data_ok.
- ms_ld_pending = ms_valid & res_from_mem & ~ready_go.

## Timing
- Reset: ms_valid 0, all latched fields 0, cancel_cnt 0, data_ok_seen 0, rdata_buf 0; hence ms_allowin 1, ms_to_ws_valid 0, all other outputs 0.
- Non-memory op: one cycle in stage if ws_allowin high.
- Load: leaves in the same cycle data_ok arrives (data combinational to ms_final_result); from buffer when stalled.
- Reset mid-wait asserts asynchronously: counter cleared; SRAM side is reset concurrently.

## Structure
- Shared package: EXC_W, load one-hot bit positions, exception-vector bit indices.
- Sub-module load_align (combinational: rdata, addr[1:0], ld_type -> 32-bit result).

## Test plan
- ld_b at addr 0x...3, rdata 0x80FF_1234, data_ok 2 cycles after accept -> stall 2 cycles, result 0xFFFF_FF80, ms_ld_pending high until then.
- ld_hu at addr 0x...2, rdata 0x8001_0000, ws_allowin low at data_ok for 3 cycles -> buffered, result 0x0000_8001 on release.
- st_w: ms_to_ws_valid only on data_ok cycle; ms_rf_we 0.
- Flush while load waiting plus es_req_accepted same cycle -> cancel_cnt 2; next two data_ok ignored; following load completes with correct data.
- es_except bit set -> ms_ex 1, ms_except matches; flush clears both next cycle.
- Back-to-back ALU ops with ws_allowin high -> one instruction per cycle, ms_final_result = es_result.
